// File: rtl/mole_round_sequencer.sv
// Whack-a-mole round controller: GAP/SHOW scheduling, hit/timeout judging, score, lives and level ramp.
// Optional MOLE_NOREPEAT_EN: never light the same segment on two consecutive moles.
module mole_round_sequencer #(
    parameter int unsigned WINDOW_INIT   = 1000000,
    parameter int unsigned WINDOW_STEP   = 62500,
    parameter int unsigned WINDOW_MIN    = 250000,
    parameter int unsigned GAP_CYCLES    = 100000,
    parameter int unsigned LEVEL_UP_HITS = 4,
    parameter int unsigned MAX_MISSES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] rand_seg,
    input  logic [7:0] btn_rise,
    output logic       mole_valid,
    output logic [2:0] mole_seg,
    output logic       hit_strobe,
    output logic       miss_strobe,
    output logic [7:0] score,
    output logic [1:0] misses,
    output logic [3:0] level,
    output logic       game_over
);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_SHOW, S_OVER} state_t;

    localparam logic [23:0] WIN_INIT_L = 24'(WINDOW_INIT);
    localparam logic [23:0] WIN_STEP_L = 24'(WINDOW_STEP);
    localparam logic [23:0] WIN_MIN_L  = 24'(WINDOW_MIN);
    localparam logic [24:0] WIN_SUM_L  = 25'(WINDOW_MIN) + 25'(WINDOW_STEP);
    localparam logic [23:0] GAP_LOAD_L = 24'(GAP_CYCLES - 1);
    localparam logic [7:0]  LVL_LAST_L = 8'(LEVEL_UP_HITS - 1);
    localparam logic [1:0]  MISS_MAX_L = 2'(MAX_MISSES);

    state_t      r_state;
    logic [23:0] r_timer;
    logic [23:0] r_window;
    logic [7:0]  r_lvl_hits;
    logic        r_mole_valid;
    logic [2:0]  r_mole_seg;
    logic        r_hit_strobe;
    logic        r_miss_strobe;
    logic [7:0]  r_score;
    logic [1:0]  r_misses;
    logic [3:0]  r_level;
    logic        r_game_over;

    logic [2:0]  w_cand;
    logic [2:0]  w_next_seg;
    logic        w_hit;
    logic [1:0]  w_misses_inc;
    logic [23:0] w_window_dec;

    assign w_cand       = (rand_seg == 3'd7) ? 3'd0 : rand_seg;
    assign w_hit        = btn_rise[r_mole_seg];
    assign w_misses_inc = r_misses + 2'd1;
    // Shrink by one step but clamp at the floor without wrapping below zero.
    assign w_window_dec = ({1'b0, r_window} >= WIN_SUM_L) ? (r_window - WIN_STEP_L) : WIN_MIN_L;

`ifdef MOLE_NOREPEAT_EN
    logic r_shown;
    assign w_next_seg = (r_shown && (w_cand == r_mole_seg))
                        ? ((w_cand == 3'd6) ? 3'd0 : w_cand + 3'd1) : w_cand;
`else
    assign w_next_seg = w_cand;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_window      <= WIN_INIT_L;
            r_lvl_hits    <= '0;
            r_mole_valid  <= 1'b0;
            r_mole_seg    <= '0;
            r_hit_strobe  <= 1'b0;
            r_miss_strobe <= 1'b0;
            r_score       <= '0;
            r_misses      <= '0;
            r_level       <= '0;
            r_game_over   <= 1'b0;
`ifdef MOLE_NOREPEAT_EN
            r_shown       <= 1'b0;
`endif
        end else begin
            r_hit_strobe  <= 1'b0;
            r_miss_strobe <= 1'b0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        r_score     <= '0;
                        r_misses    <= '0;
                        r_level     <= '0;
                        r_lvl_hits  <= '0;
                        r_window    <= WIN_INIT_L;
                        r_timer     <= GAP_LOAD_L;
                        r_game_over <= 1'b0;
                        r_state     <= S_GAP;
`ifdef MOLE_NOREPEAT_EN
                        r_shown     <= 1'b0;
`endif
                    end
                end
                S_GAP: begin
                    if (r_timer == '0) begin
                        r_mole_seg   <= w_next_seg;
                        r_timer      <= r_window - 24'd1;
                        r_mole_valid <= 1'b1;
                        r_state      <= S_SHOW;
`ifdef MOLE_NOREPEAT_EN
                        r_shown      <= 1'b1;
`endif
                    end else begin
                        r_timer <= r_timer - 24'd1;
                    end
                end
                S_SHOW: begin
                    // A press landing on the timeout cycle still wins as a hit.
                    if (w_hit) begin
                        r_hit_strobe <= 1'b1;
                        r_mole_valid <= 1'b0;
                        if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                        if (r_lvl_hits == LVL_LAST_L) begin
                            r_lvl_hits <= '0;
                            r_window   <= w_window_dec;
                            if (r_level != 4'hF) r_level <= r_level + 4'd1;
                        end else begin
                            r_lvl_hits <= r_lvl_hits + 8'd1;
                        end
                        r_timer <= GAP_LOAD_L;
                        r_state <= S_GAP;
                    end else if (r_timer == '0) begin
                        r_miss_strobe <= 1'b1;
                        r_mole_valid  <= 1'b0;
                        r_misses      <= w_misses_inc;
                        if (w_misses_inc == MISS_MAX_L) begin
                            r_game_over <= 1'b1;
                            r_state     <= S_OVER;
                        end else begin
                            r_timer <= GAP_LOAD_L;
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_timer <= r_timer - 24'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mole_valid  = r_mole_valid;
    assign mole_seg    = r_mole_seg;
    assign hit_strobe  = r_hit_strobe;
    assign miss_strobe = r_miss_strobe;
    assign score       = r_score;
    assign misses      = r_misses;
    assign level       = r_level;
    assign game_over   = r_game_over;

endmodule

// File: tb/tb_mole_round_sequencer.sv
// Directed bench for mole_round_sequencer with shortened windows (20/4/8, gap 5, 2 hits per level, 3 lives).
module tb_mole_round_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] rand_seg;
    logic [7:0] btn_rise;
    logic       mole_valid;
    logic [2:0] mole_seg;
    logic       hit_strobe;
    logic       miss_strobe;
    logic [7:0] score;
    logic [1:0] misses;
    logic [3:0] level;
    logic       game_over;

    int n_cmp = 0;
    int n_err = 0;

    mole_round_sequencer #(
        .WINDOW_INIT(20), .WINDOW_STEP(4), .WINDOW_MIN(8),
        .GAP_CYCLES(5), .LEVEL_UP_HITS(2), .MAX_MISSES(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rand_seg(rand_seg), .btn_rise(btn_rise),
        .mole_valid(mole_valid), .mole_seg(mole_seg), .hit_strobe(hit_strobe),
        .miss_strobe(miss_strobe), .score(score), .misses(misses), .level(level),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Edges until mole_valid rises; -1 when the bound expires.
    task automatic wait_valid(output int n);
        n = 0;
        while (!mole_valid && n < 200) begin
            tick();
            n++;
        end
        if (!mole_valid) n = -1;
    endtask

    // Number of sampled cycles the current mole stays visible with no presses.
    task automatic measure(output int n);
        n = 0;
        while (mole_valid && n < 200) begin
            n++;
            tick();
        end
        $display("timeout: visible=%0d misses=%0d game_over=%0d", n, misses, game_over);
    endtask

    task automatic hit_round();
        int n;
        wait_valid(n);
        btn_rise = 8'd1 << mole_seg;
        tick();
        btn_rise = '0;
        $display("hit: seg=%0d score=%0d level=%0d", mole_seg, score, level);
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; start = 1'b0; rand_seg = '0; btn_rise = '0;
        tick(); tick();
        n_cmp++;
        if ({mole_valid, mole_seg, hit_strobe, miss_strobe, score, misses, level, game_over} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h need 0", {mole_valid, mole_seg, hit_strobe, miss_strobe, score, misses, level, game_over});
        end
        rst = 1'b0;
        tick();
        rand_seg = 3'd3;
        pulse_start();
        wait_valid(n);
        tick(); tick();
        n_cmp++;
        if (mole_valid !== 1'b1 || mole_seg !== 3'd3) begin
            n_err++;
            $display("FAIL pre_reset_show: valid=%b seg=%0d need 1/3", mole_valid, mole_seg);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({mole_valid, mole_seg, hit_strobe, miss_strobe, score, misses, level, game_over} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got %h need 0", {mole_valid, mole_seg, hit_strobe, miss_strobe, score, misses, level, game_over});
        end
        tick();
        rst = 1'b0;
        tick();
        rand_seg = 3'd3;
        pulse_start();
        wait_valid(n);
        n_cmp++;
        if (n !== 5) begin n_err++; $display("FAIL first_mole_latency: got %0d need 5", n); end
        n_cmp++;
        if (mole_seg !== 3'd3) begin n_err++; $display("FAIL first_mole_seg: got %0d need 3", mole_seg); end
    endtask

    task automatic test_hit();
        int n;
        btn_rise = 8'h08;
        tick();
        btn_rise = '0;
        $display("hit: seg=%0d score=%0d", mole_seg, score);
        n_cmp++;
        if (hit_strobe !== 1'b1 || score !== 8'd1 || mole_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hit_response: strobe=%b score=%0d valid=%b need 1/1/0", hit_strobe, score, mole_valid);
        end
        rand_seg = 3'd4;
        tick();
        n_cmp++;
        if (hit_strobe !== 1'b0) begin n_err++; $display("FAIL hit_strobe_width: got %b need 0", hit_strobe); end
        wait_valid(n);
        n_cmp++;
        if (n !== 4) begin n_err++; $display("FAIL hit_to_next_mole: got %0d need 4", n); end
        n_cmp++;
        if (mole_seg !== 3'd4) begin n_err++; $display("FAIL second_mole_seg: got %0d need 4", mole_seg); end
    endtask

    task automatic test_wrong_and_tie();
        int n;
        btn_rise = 8'h01;
        tick();
        btn_rise = '0;
        n_cmp++;
        if (hit_strobe !== 1'b0 || miss_strobe !== 1'b0 || mole_valid !== 1'b1 || score !== 8'd1) begin
            n_err++;
            $display("FAIL wrong_press: strobe=%b miss=%b valid=%b score=%0d need 0/0/1/1", hit_strobe, miss_strobe, mole_valid, score);
        end
        for (int i = 0; i < 18; i++) tick();
        n_cmp++;
        if (mole_valid !== 1'b1) begin n_err++; $display("FAIL window_after_wrong: valid=%b at cycle 20 need 1", mole_valid); end
        btn_rise = 8'h10;
        tick();
        btn_rise = '0;
        $display("tie: hit=%b miss=%b score=%0d", hit_strobe, miss_strobe, score);
        n_cmp++;
        if (hit_strobe !== 1'b1 || miss_strobe !== 1'b0 || misses !== 2'd0 || score !== 8'd2 || level !== 4'd1) begin
            n_err++;
            $display("FAIL tie_hit_wins: hit=%b miss=%b misses=%0d score=%0d level=%0d need 1/0/0/2/1", hit_strobe, miss_strobe, misses, score, level);
        end
        rand_seg = 3'd7;
        wait_valid(n);
        n_cmp++;
        if (mole_seg !== 3'd0) begin n_err++; $display("FAIL rand7_maps_0: got %0d need 0", mole_seg); end
    endtask

    task automatic test_levels_and_over();
        int n;
        do_reset();
        rand_seg = 3'd2;
        pulse_start();
        wait_valid(n);
        measure(n);
        n_cmp++;
        if (n !== 20) begin n_err++; $display("FAIL window_l0: got %0d need 20", n); end
        n_cmp++;
        if (miss_strobe !== 1'b1 || misses !== 2'd1 || game_over !== 1'b0) begin
            n_err++;
            $display("FAIL miss1: strobe=%b misses=%0d over=%b need 1/1/0", miss_strobe, misses, game_over);
        end
        hit_round();
        hit_round();
        n_cmp++;
        if (level !== 4'd1 || score !== 8'd2) begin n_err++; $display("FAIL level1: level=%0d score=%0d need 1/2", level, score); end
        wait_valid(n);
        measure(n);
        n_cmp++;
        if (n !== 16) begin n_err++; $display("FAIL window_l1: got %0d need 16", n); end
        n_cmp++;
        if (misses !== 2'd2 || game_over !== 1'b0) begin n_err++; $display("FAIL miss2: misses=%0d over=%b need 2/0", misses, game_over); end
        for (int k = 3; k <= 8; k++) begin
            hit_round();
            if (k % 2 == 0) begin
                n_cmp++;
                if (level !== 4'(k / 2)) begin n_err++; $display("FAIL level_after_hit%0d: got %0d need %0d", k, level, k / 2); end
            end
        end
        wait_valid(n);
        measure(n);
        n_cmp++;
        if (n !== 8) begin n_err++; $display("FAIL window_l4_floor: got %0d need 8", n); end
        n_cmp++;
        if (game_over !== 1'b1 || misses !== 2'd3 || mole_valid !== 1'b0 || miss_strobe !== 1'b1) begin
            n_err++;
            $display("FAIL game_over_entry: over=%b misses=%0d valid=%b miss=%b need 1/3/0/1", game_over, misses, mole_valid, miss_strobe);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (game_over !== 1'b1 || score !== 8'd8 || level !== 4'd4 || mole_valid !== 1'b0 || miss_strobe !== 1'b0) begin
            n_err++;
            $display("FAIL over_hold: over=%b score=%0d level=%0d valid=%b miss=%b need 1/8/4/0/0", game_over, score, level, mole_valid, miss_strobe);
        end
        pulse_start();
        n_cmp++;
        if (score !== 8'd0 || misses !== 2'd0 || level !== 4'd0 || game_over !== 1'b0) begin
            n_err++;
            $display("FAIL restart_clear: score=%0d misses=%0d level=%0d over=%b need 0/0/0/0", score, misses, level, game_over);
        end
        for (int k = 0; k < 4; k++) hit_round();
        wait_valid(n);
        measure(n);
        n_cmp++;
        if (n !== 12) begin n_err++; $display("FAIL window_l2: got %0d need 12", n); end
        hit_round();
        hit_round();
        n_cmp++;
        if (level !== 4'd3 || misses !== 2'd1) begin n_err++; $display("FAIL level3: level=%0d misses=%0d need 3/1", level, misses); end
        wait_valid(n);
        measure(n);
        n_cmp++;
        if (n !== 8) begin n_err++; $display("FAIL window_l3: got %0d need 8", n); end
    endtask

    task automatic test_norepeat();
        int n;
        logic [2:0] exp_second;
        do_reset();
        rand_seg = 3'd5;
        pulse_start();
        wait_valid(n);
        n_cmp++;
        if (mole_seg !== 3'd5) begin n_err++; $display("FAIL repeat5_first: got %0d need 5", mole_seg); end
        hit_round();
        wait_valid(n);
`ifdef MOLE_NOREPEAT_EN
        exp_second = 3'd6;
`else
        exp_second = 3'd5;
`endif
        n_cmp++;
        if (mole_seg !== exp_second) begin n_err++; $display("FAIL repeat5_second: got %0d need %0d", mole_seg, exp_second); end
        do_reset();
        rand_seg = 3'd6;
        pulse_start();
        wait_valid(n);
        n_cmp++;
        if (mole_seg !== 3'd6) begin n_err++; $display("FAIL repeat6_first: got %0d need 6", mole_seg); end
        hit_round();
        wait_valid(n);
`ifdef MOLE_NOREPEAT_EN
        exp_second = 3'd0;
`else
        exp_second = 3'd6;
`endif
        n_cmp++;
        if (mole_seg !== exp_second) begin n_err++; $display("FAIL repeat6_second: got %0d need %0d", mole_seg, exp_second); end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_wrong_and_tie();
        test_levels_and_over();
        test_norepeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
